// File: rtl/dff_pkg.sv
// dff_pkg: FSM states, error-log entry type and log depth shared by dff_scoreboard
package dff_pkg;
  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;
  localparam int LOG_DEPTH = 4;
  localparam int LOG_IDX_W = 16;
  localparam int LOG_VAL_W = 1;
  typedef struct packed {
    logic [LOG_IDX_W-1:0] idx;
    logic [LOG_VAL_W-1:0] exp;
    logic [LOG_VAL_W-1:0] act;
  } log_entry_t;
endpackage

// File: rtl/dff_sb_fifo.sv
// dff_sb_fifo: LOG_DEPTH-entry mismatch log; drops pushes when full and flags a sticky overflow
module dff_sb_fifo
  import dff_pkg::*;
#(
  parameter type T = log_entry_t
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop_ready,
  input  logic i_ovf_clr,
  output logic o_valid,
  output T     o_data,
  output logic o_ovf
);
  localparam int AW = $clog2(LOG_DEPTH);
  localparam int CW = AW + 1;
  T r_mem [LOG_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  logic r_ovf, w_pop, w_push, w_full;
  assign w_full = r_cnt == CW'(LOG_DEPTH);
  assign o_valid = r_cnt != '0;
  assign w_pop = o_valid && i_pop_ready;
  assign w_push = i_push && (!w_full || w_pop);
  assign o_data = r_mem[r_rd];
  assign o_ovf = r_ovf;
  // ring buffer pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) r_mem[r_wr] <= i_data;
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_ovf <= (i_push && !w_push) ? 1'b1 : i_ovf_clr ? 1'b0 : r_ovf;
    end
  end
endmodule

// File: rtl/dff_scoreboard.sv
// dff_scoreboard: compares a flip-flop's q against its d delayed LATENCY cycles; DFF_SCOREBOARD_ERRLOG_EN adds a mismatch log FIFO
module dff_scoreboard
  import dff_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CNT_W-1:0]          num_checks,
  input  logic [WIDTH-1:0]          d_obs,
  input  logic [WIDTH-1:0]          q_obs,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [CNT_W-1:0]          chk_cnt,
  output logic [CNT_W-1:0]          err_cnt,
  output logic [CNT_W-1:0]          first_err_idx,
  output logic [WIDTH-1:0]          first_err_exp,
  output logic [WIDTH-1:0]          first_err_act
`ifdef DFF_SCOREBOARD_ERRLOG_EN
  ,
  output logic                      log_valid,
  input  logic                      log_ready,
  output logic [CNT_W+2*WIDTH-1:0]  log_data,
  output logic                      log_ovf
`endif
);
  state_t r_state, w_state_nxt;
  logic [WIDTH-1:0] r_pipe [LATENCY];
  logic [2:0] r_fill;
  logic [CNT_W-1:0] r_num, r_chk, r_err, r_fidx;
  logic [WIDTH-1:0] w_exp, r_fexp, r_fact;
  logic r_pass, w_go, w_cmp, w_mis, w_last;
  assign w_exp = r_pipe[LATENCY-1];
  assign w_go = (r_state == IDLE) && start;
  assign w_cmp = r_state == RUN;
  assign w_mis = w_cmp && (q_obs !== w_exp);
  assign w_last = w_cmp && (r_chk + CNT_W'(1) == r_num);
  assign busy = (r_state == FILL) || (r_state == RUN);
  assign done = r_state == DONE;
  assign pass = r_pass;
  assign chk_cnt = r_chk;
  assign err_cnt = r_err;
  assign first_err_idx = r_fidx;
  assign first_err_exp = r_fexp;
  assign first_err_act = r_fact;
  // expected-value pipeline runs in every state so it is primed before RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= d_obs;
      for (int i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end
  // state register and FILL-phase cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_fill  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fill  <= (r_state == FILL) ? r_fill + 3'd1 : 3'd0;
    end
  end
  // next-state: an empty run skips straight to DONE
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (start) w_state_nxt = (num_checks == '0) ? DONE : FILL;
      FILL: if (r_fill == 3'(LATENCY - 1)) w_state_nxt = RUN;
      RUN:  if (w_last) w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end
  // run bookkeeping: counters, first-error capture and the verdict taken on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_num  <= '0;
      r_chk  <= '0;
      r_err  <= '0;
      r_fidx <= '0;
      r_fexp <= '0;
      r_fact <= '0;
      r_pass <= 1'b0;
    end else if (w_go) begin
      r_num  <= num_checks;
      r_chk  <= '0;
      r_err  <= '0;
      r_fidx <= '0;
      r_fexp <= '0;
      r_fact <= '0;
      r_pass <= num_checks == '0;
    end else begin
      if (w_cmp) r_chk <= r_chk + CNT_W'(1);
      if (w_mis && r_err != '1) r_err <= r_err + CNT_W'(1);
      if (w_mis && r_err == '0) r_fidx <= r_chk;
      if (w_mis && r_err == '0) r_fexp <= w_exp;
      if (w_mis && r_err == '0) r_fact <= q_obs;
      if (w_last) r_pass <= (r_err == '0) && !w_mis;
    end
  end
`ifdef DFF_SCOREBOARD_ERRLOG_EN
  dff_sb_fifo #(.T(logic [CNT_W+2*WIDTH-1:0])) u_log (
    .clk(clk),
    .rst(rst),
    .i_push(w_mis),
    .i_data({r_chk, w_exp, q_obs}),
    .i_pop_ready(log_ready),
    .i_ovf_clr(w_go),
    .o_valid(log_valid),
    .o_data(log_data),
    .o_ovf(log_ovf)
  );
`endif
endmodule

// File: tb/tb_dff_scoreboard.sv
// tb_dff_scoreboard: random-stimulus bench for two dff_scoreboard configs; DFF_SCOREBOARD_ERRLOG_EN also exercises the error log
module tb_dff_scoreboard;
  localparam int N = 4096;
  localparam int LAT [2] = '{1, 3};
  localparam logic [3:0] MSK [2] = '{4'h1, 4'hF};
  typedef struct {
    bit busy, done, pass;
    int chk, err, fidx;
    logic [3:0] fexp, fact;
  } exp_t;
  logic clk = 1'b0;
  logic rst, start, log_ready;
  logic [15:0] num;
  logic [3:0] d_in [2], q_in [2];
  logic busy_o [2], done_o [2], pass_o [2];
  logic [15:0] chk_o [2], err_o [2], fidx_o [2];
  logic [3:0] fexp_o [2], fact_o [2];
  logic fexp_a, fact_a;
  logic [3:0] hd [2][N], hq [2][N];
  bit has_run [2];
  int rs [2], rn [2];
  int cyc, n_pass, n_chk;
`ifdef DFF_SCOREBOARD_ERRLOG_EN
  logic lv_o [2], lo_o [2];
  logic [17:0] ld_a;
  logic [23:0] ld_b;
`endif
  assign fexp_o[0] = {3'b0, fexp_a};
  assign fact_o[0] = {3'b0, fact_a};
  always #5 clk = ~clk;
  dff_scoreboard #(.WIDTH(1), .LATENCY(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .start(start), .num_checks(num),
    .d_obs(d_in[0][0]), .q_obs(q_in[0][0]),
    .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
    .chk_cnt(chk_o[0]), .err_cnt(err_o[0]), .first_err_idx(fidx_o[0]),
    .first_err_exp(fexp_a), .first_err_act(fact_a)
`ifdef DFF_SCOREBOARD_ERRLOG_EN
    , .log_valid(lv_o[0]), .log_ready(log_ready), .log_data(ld_a), .log_ovf(lo_o[0])
`endif
  );
  dff_scoreboard #(.WIDTH(4), .LATENCY(3), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .start(start), .num_checks(num),
    .d_obs(d_in[1]), .q_obs(q_in[1]),
    .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
    .chk_cnt(chk_o[1]), .err_cnt(err_o[1]), .first_err_idx(fidx_o[1]),
    .first_err_exp(fexp_o[1]), .first_err_act(fact_o[1])
`ifdef DFF_SCOREBOARD_ERRLOG_EN
    , .log_valid(lv_o[1]), .log_ready(log_ready), .log_data(ld_b), .log_ovf(lo_o[1])
`endif
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    else n_pass++;
  endtask
  // expected outputs at cycle c, derived from the run's start cycle, length and recorded d/q history
  task automatic model(input int i, input int c, output exp_t e);
    int s, n, l, last, ncmp, cc;
    logic [3:0] x;
    e = '{default: 0};
    if (!has_run[i]) return;
    s = rs[i];
    n = rn[i];
    l = LAT[i];
    if (n == 0) begin
      e.done = (c == s + 1);
      e.pass = 1'b1;
      return;
    end
    last = s + l + n;
    ncmp = c - (s + l + 1);
    if (ncmp < 0) ncmp = 0;
    if (ncmp > n) ncmp = n;
    e.busy = c <= last;
    e.done = c == last + 1;
    e.chk = ncmp;
    for (int k = 0; k < ncmp; k++) begin
      cc = s + l + 1 + k;
      x = hd[i][cc-l];
      if (hq[i][cc] != x) begin
        if (e.err == 0) begin
          e.fidx = k;
          e.fexp = x;
          e.fact = hq[i][cc];
        end
        e.err++;
      end
    end
    e.pass = (c > last) && (e.err == 0);
  endtask
  // one clock cycle: drive inputs, check both DUTs against the model, then advance the model
  task automatic step(input bit st, input bit r, input int n, input int mode, input logic [31:0] mask);
    exp_t e;
    @(posedge clk);
    cyc++;
    if (cyc >= N) begin
      $display("FAIL history overflow at cycle %0d", cyc);
      $fatal(1);
    end
    #1;
    rst = r;
    start = st;
    num = 16'(n);
    for (int i = 0; i < 2; i++) begin
      logic [3:0] d, q;
      int k;
      d = 4'($urandom) & MSK[i];
      q = (cyc >= LAT[i]) ? hd[i][cyc-LAT[i]] : 4'h0;
      k = has_run[i] ? cyc - (rs[i] + LAT[i] + 1) : -1;
      if (mode == 1 && k >= 0 && k < 32 && mask[k]) q = q ^ MSK[i];
      if (mode == 2 && $urandom_range(7) == 0) q = q ^ MSK[i];
      d_in[i] = d;
      q_in[i] = q;
      hd[i][cyc] = r ? 4'h0 : d;
      hq[i][cyc] = q;
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      model(i, cyc, e);
      chk($sformatf("u%0d busy", i), 32'(busy_o[i]), 32'(e.busy));
      chk($sformatf("u%0d done", i), 32'(done_o[i]), 32'(e.done));
      chk($sformatf("u%0d pass", i), 32'(pass_o[i]), 32'(e.pass));
      chk($sformatf("u%0d chk_cnt", i), 32'(chk_o[i]), e.chk);
      chk($sformatf("u%0d err_cnt", i), 32'(err_o[i]), e.err);
      chk($sformatf("u%0d first_err_idx", i), 32'(fidx_o[i]), e.fidx);
      chk($sformatf("u%0d first_err_exp", i), 32'(fexp_o[i]), 32'(e.fexp));
      chk($sformatf("u%0d first_err_act", i), 32'(fact_o[i]), 32'(e.fact));
    end
    for (int i = 0; i < 2; i++) begin
      model(i, cyc, e);
      if (r) has_run[i] = 0;
      else if (st && !e.busy && !e.done) begin
        has_run[i] = 1;
        rs[i] = cyc;
        rn[i] = n;
      end
    end
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    num = '0;
    log_ready = 1'b1;
    cyc = 0;
    n_pass = 0;
    n_chk = 0;
    for (int i = 0; i < 2; i++) begin
      d_in[i] = '0;
      q_in[i] = '0;
      hd[i][0] = '0;
      hq[i][0] = '0;
      has_run[i] = 0;
    end
    repeat (9) step(0, 1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    chk("reset state", {busy_o[0], done_o[0], pass_o[0], chk_o[0], err_o[0]}, 0);
    step(1, 0, 20, 0, 0);
    repeat (26) step(0, 0, 20, 0, 0);
    chk("ideal chk_cnt", 32'(chk_o[0]), 20);
    chk("ideal err_cnt", 32'(err_o[0]), 0);
    chk("ideal pass", 32'(pass_o[0]), 1);
    step(1, 0, 20, 1, (32'd1 << 5) | (32'd1 << 9));
    repeat (26) step(0, 0, 20, 1, (32'd1 << 5) | (32'd1 << 9));
    chk("inject err_cnt", 32'(err_o[0]), 2);
    chk("inject first_idx", 32'(fidx_o[0]), 5);
    chk("inject exp vs act", 32'(fexp_a ^ fact_a), 1);
    chk("inject pass", 32'(pass_o[1]), 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("empty run done", 32'(done_o[0]), 1);
    chk("empty run pass", 32'(pass_o[1]), 1);
    step(0, 0, 0, 0, 0);
    step(1, 0, 15, 0, 0);
    repeat (8) step(0, 0, 15, 0, 0);
    step(1, 0, 3, 0, 0);
    repeat (14) step(0, 0, 3, 0, 0);
    chk("ignored start chk_cnt", 32'(chk_o[1]), 15);
    step(1, 0, 20, 0, 0);
    repeat (11) step(0, 0, 20, 0, 0);
    step(0, 1, 20, 0, 0);
    step(0, 0, 20, 0, 0);
    chk("abort busy", 32'(busy_o[0]), 0);
    chk("abort chk_cnt", 32'(chk_o[1]), 0);
    repeat (4) step(0, 0, 0, 0, 0);
    repeat (12) begin
      step(1, 0, int'($urandom_range(1, 30)), 2, 0);
      repeat ($urandom_range(0, 40)) step($urandom_range(0, 9) == 0, 0, int'($urandom_range(0, 30)), 2, 0);
    end
    repeat (45) step(0, 0, 0, 2, 0);
`ifdef DFF_SCOREBOARD_ERRLOG_EN
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    log_ready = 1'b0;
    step(1, 0, 10, 1, 32'h3F);
    repeat (16) step(0, 0, 10, 1, 32'h3F);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d log_valid full", i), 32'(lv_o[i]), 1);
      chk($sformatf("u%0d log_ovf", i), 32'(lo_o[i]), 1);
    end
    log_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [3:0] ex0, ac0, ex1, ac1;
      ex0 = hd[0][rs[0] + 1 + k];
      ac0 = hq[0][rs[0] + 2 + k];
      ex1 = hd[1][rs[1] + 1 + k];
      ac1 = hq[1][rs[1] + 4 + k];
      chk($sformatf("u0 log_data %0d", k), 32'(ld_a), 32'({16'(k), ex0[0], ac0[0]}));
      chk($sformatf("u1 log_data %0d", k), 32'(ld_b), 32'({16'(k), ex1, ac1}));
      step(0, 0, 0, 0, 0);
    end
    chk("u0 log drained", 32'(lv_o[0]), 0);
    chk("u1 log drained", 32'(lv_o[1]), 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dff_scoreboard.md
DFF_SCOREBOARD -- requirements
Module: dff_scoreboard

Interface
REQ-001 Parameter WIDTH, default 1: bit width of observed d and q.
REQ-002 Parameter LATENCY, default 1, legal 1..8: DUT cycles from d sample to q update.
REQ-003 Parameter CNT_W, default 16: width of count ports and num_checks.
REQ-004 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-005 Port rst  input  1: synchronous, active-high reset.
REQ-006 Port start  input  1: single-cycle request to begin a check run.
REQ-007 Port num_checks  input  CNT_W: number of compares in the run, sampled on accepted start.
REQ-008 Port d_obs  input  WIDTH: value presented to the DUT d input this cycle.
REQ-009 Port q_obs  input  WIDTH: DUT q output this cycle.
REQ-010 Port busy  output  1: high in FILL or RUN.
REQ-011 Port done  output  1: one-cycle pulse at run completion.
REQ-012 Port pass  output  1: run result, valid from done until next accepted start.
REQ-013 Port chk_cnt  output  CNT_W: compares performed in the current or last run.
REQ-014 Port err_cnt  output  CNT_W: mismatches in the current or last run, saturating.
REQ-015 Port first_err_idx  output  CNT_W: chk_cnt value at the first mismatch.
REQ-016 Port first_err_exp / first_err_act  output  WIDTH each: expected and actual at the first mismatch.

Function
REQ-017 An expected-value shift register of LATENCY stages SHALL capture d_obs every cycle, including IDLE, so the expected value is q_obs(t) == d_obs(t-LATENCY).
REQ-018 FSM states SHALL be IDLE, FILL, RUN and DONE.
- IDLE: start accepted -> FILL; counters and first-error fields cleared; pass cleared.
- FILL: LATENCY cycles, no compares -> RUN.
- RUN: one compare per cycle -> DONE in the cycle chk_cnt reaches num_checks.
- DONE: one cycle, done=1 -> IDLE.
REQ-019 Accepted start with num_checks==0 SHALL go IDLE->DONE directly, with pass=1 and chk_cnt=0.
REQ-020 start in FILL, RUN or DONE SHALL be ignored.
REQ-021 Each RUN compare SHALL increment chk_cnt; a mismatch SHALL also increment err_cnt, which saturates at all-ones.
REQ-022 The first mismatch of a run SHALL latch first_err_idx, first_err_exp and first_err_act; later mismatches leave them unchanged.
REQ-023 pass SHALL equal (err_cnt==0) when entering DONE and hold until the next accepted start.
REQ-024 Compares SHALL use full WIDTH bitwise equality; X or Z on q_obs counts as a mismatch in simulation.

Reset
REQ-025 rst SHALL force IDLE at any point, including mid-run, with no done pulse for the aborted run.
REQ-026 Reset values SHALL be busy=0, done=0, pass=0, all counts=0, first_err fields=0, and the expected pipeline=0.

Configuration
REQ-027 Macro DFF_SCOREBOARD_ERRLOG_EN, when defined, SHALL add a 4-entry error-log FIFO of {idx, exp, act} per mismatch.
REQ-028 With the macro, the added ports SHALL be log_valid out 1, log_ready in 1, log_data out CNT_W+2*WIDTH, and log_ovf out 1.
REQ-029 The FIFO SHALL pop when log_valid&&log_ready, and push on a mismatch.
- Full with simultaneous push and pop: both occur.
- Full with push only: the entry is dropped and log_ovf is set.
- log_ovf is sticky and cleared by rst or an accepted start.
- The FIFO is not flushed by start.
REQ-030 Without the macro, the log ports and logic SHALL be absent and all other behaviour is identical.

Structure
REQ-031 Package dff_pkg SHALL hold the FSM state enum, the log-entry struct typedef and LOG_DEPTH=4.
REQ-032 The error log SHALL be sub-module dff_sb_fifo, instantiated only under DFF_SCOREBOARD_ERRLOG_EN.

Verification
REQ-033 Scenario: rst held 10 cycles, then released -> all outputs 0 and state IDLE.
REQ-034 Scenario: WIDTH=1, LATENCY=1, num_checks=20, ideal DFF -> done after 1+20 cycles, pass=1, chk_cnt=20, err_cnt=0.
REQ-035 Scenario: q forced inverted on compares 5 and 9 -> err_cnt=2, first_err_idx=5, first_err_exp=!first_err_act, pass=0.
REQ-036 Scenario: num_checks=0 -> done the cycle after start, pass=1; start pulsed during RUN -> ignored, run length unchanged.
REQ-037 Scenario: rst asserted at compare 10 of 20 -> no done pulse, IDLE next cycle, counts 0.
REQ-038 Scenario: with the macro, 6 mismatches and log_ready=0 -> 4 entries held, log_ovf=1, and entries pop in order once log_ready=1.
